// File: rtl/cory_unpackn_pkg.sv
// Shared constants and helpers for the cory_unpackn word-to-channel unpacker.
// - CMin/CMax: legal channel-count range; WMin: minimum lane width.
// - cfg_ok(): legal-range check for the (C, W, Q) parameter set.
// - lane_lo(): low bit index of lane k inside a packed word of W-bit lanes.
package cory_unpackn_pkg;

  localparam int unsigned CMin = 2;
  localparam int unsigned CMax = 16;
  localparam int unsigned WMin = 1;

  // Q is unsigned, so any value (0 = pass-through, >= 1 = queue depth) is legal.
  function automatic bit cfg_ok(int unsigned c, int unsigned w, int unsigned q);
    return (c >= CMin) && (c <= CMax) && (w >= WMin) && (q == q);
  endfunction

  function automatic int unsigned lane_lo(int unsigned k, int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/cory_unpackn_if.sv
// Handshake bundle between a word source and the cory_unpackn channel sinks.
// Optional macro: CORY_UNPACKN_MASK_EN adds the per-channel emit mask i_a_m.
// Signals:
//   i_a_v/i_a_d/(i_a_m)  input word valid, packed data, emit mask
//   o_a_r                input word accepted this cycle
//   o_z_v/o_z_d/i_z_r    per-channel output valid, packed data, ready
//   o_sent               sticky per-channel delivered flags
// master = source/sink side (drives inputs), slave = the unpacker.
interface cory_unpackn_if #(
  parameter int unsigned C = 4,
  parameter int unsigned W = 8
);
  logic             i_a_v;
  logic [C*W-1:0]   i_a_d;
`ifdef CORY_UNPACKN_MASK_EN
  logic [C-1:0]     i_a_m;
`endif
  logic             o_a_r;
  logic [C-1:0]     o_z_v;
  logic [C*W-1:0]   o_z_d;
  logic [C-1:0]     i_z_r;
  logic [C-1:0]     o_sent;

  modport master (
`ifdef CORY_UNPACKN_MASK_EN
    output i_a_m,
`endif
    output i_a_v, i_a_d, i_z_r,
    input  o_a_r, o_z_v, o_z_d, o_sent
  );

  modport slave (
`ifdef CORY_UNPACKN_MASK_EN
    input  i_a_m,
`endif
    input  i_a_v, i_a_d, i_z_r,
    output o_a_r, o_z_v, o_z_d, o_sent
  );
endinterface

// File: rtl/cory_queue.sv
// Per-channel output queue for cory_unpackn.
// Q = 0: combinational pass-through; Q = 1: single register; Q >= 2: circular FIFO.
// Ports: clk, reset_n (async, active-low); in_v_i/in_d_i/in_r_o push side;
// out_v_o/out_d_o/out_r_i pop side. in_r_o never depends on out_r_i when Q >= 1.
module cory_queue #(
  parameter int unsigned N = 8,
  parameter int unsigned Q = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_v_i,
  input  logic [N-1:0] in_d_i,
  output logic         in_r_o,
  output logic         out_v_o,
  output logic [N-1:0] out_d_o,
  input  logic         out_r_i
);

  if (Q == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset_n;
    assign out_v_o = in_v_i;
    assign out_d_o = in_d_i;
    assign in_r_o  = out_r_i;
  end else if (Q == 1) begin : g_reg
    logic         v_q, v_d;
    logic [N-1:0] d_q;

    assign in_r_o  = ~v_q;
    assign out_v_o = v_q;
    assign out_d_o = d_q;

    always_comb begin
      v_d = v_q;
      if (!v_q)         v_d = in_v_i;
      else if (out_r_i) v_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) v_q <= 1'b0;
      else          v_q <= v_d;
    end

    // Data needs no reset: it is only observed while v_q is set.
    always_ff @(posedge clk) begin
      if (in_v_i && !v_q) d_q <= in_d_i;
    end
  end else begin : g_fifo
    localparam int unsigned PtrW = $clog2(Q);
    localparam int unsigned CntW = $clog2(Q + 1);

    logic [N-1:0]    mem_q [Q];
    logic [PtrW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            push, pop;

    assign in_r_o  = (cnt_q != CntW'(Q));
    assign out_v_o = (cnt_q != '0);
    assign out_d_o = mem_q[rd_q];
    assign push    = in_v_i & in_r_o;
    assign pop     = out_v_o & out_r_i;

    always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (push) wr_d = (wr_q == PtrW'(Q - 1)) ? '0 : wr_q + PtrW'(1);
      if (pop)  rd_d = (rd_q == PtrW'(Q - 1)) ? '0 : rd_q + PtrW'(1);
      if (push && !pop)      cnt_d = cnt_q + CntW'(1);
      else if (pop && !push) cnt_d = cnt_q - CntW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
      end else begin
        wr_q  <= wr_d;
        rd_q  <= rd_d;
        cnt_q <= cnt_d;
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= in_d_i;
    end
  end

endmodule

// File: rtl/cory_unpackn.sv
// cory_unpackn: splits one C*W-bit input word into C W-bit channel outputs.
// Each channel is emitted exactly once per word; the word is accepted (o_a_r) in
// the cycle the last pending channel fires. A sticky sent flag per channel records
// channels already handed to their queue for the current word.
// Optional macro: CORY_UNPACKN_MASK_EN enables the per-channel emit mask i_a_m.
// Ports: clk, reset_n (async, active-low), a_if (cory_unpackn_if.slave).
module cory_unpackn
  import cory_unpackn_pkg::*;
#(
  parameter int unsigned C = 4,
  parameter int unsigned W = 8,
  parameter int unsigned Q = 0
) (
  input logic            clk,
  input logic            reset_n,
  cory_unpackn_if.slave  a_if
);

  localparam int unsigned A = C * W;

  if (!cfg_ok(C, W, Q)) begin : g_cfg_err
    $error("cory_unpackn: illegal parameters C=%0d W=%0d Q=%0d", C, W, Q);
  end

  logic [C-1:0] mask, int_v, int_r, fire, done;
  logic [C-1:0] sent_q, sent_d;
  logic [C-1:0] z_v;
  logic [A-1:0] z_d;
  logic         acc;

`ifdef CORY_UNPACKN_MASK_EN
  assign mask = a_if.i_a_m;
`else
  assign mask = '1;
`endif

  always_comb begin
    int_v  = {C{a_if.i_a_v}} & ~sent_q & mask;
    fire   = int_v & int_r;
    // Masked-off channels count as already complete.
    done   = fire | sent_q | ~mask;
    acc    = a_if.i_a_v & (&done);
    sent_d = acc ? '0 : (sent_q | fire);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sent_q <= '0;
    else          sent_q <= sent_d;
  end

  for (genvar k = 0; k < C; k++) begin : g_lane
    cory_queue #(
      .N(W),
      .Q(Q)
    ) u_queue (
      .clk     (clk),
      .reset_n (reset_n),
      .in_v_i  (int_v[k]),
      .in_d_i  (a_if.i_a_d[lane_lo(k, W) +: W]),
      .in_r_o  (int_r[k]),
      .out_v_o (z_v[k]),
      .out_d_o (z_d[lane_lo(k, W) +: W]),
      .out_r_i (a_if.i_z_r[k])
    );
  end

  assign a_if.o_a_r  = acc;
  assign a_if.o_z_v  = z_v;
  assign a_if.o_z_d  = z_d;
  assign a_if.o_sent = sent_q;

endmodule

// File: tb/tb_cory_unpackn.sv
// Bench for cory_unpackn: a C=4/W=8/Q=1 instance and a C=2/W=8/Q=0 instance.
module tb_cory_unpackn;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  cory_unpackn_if #(.C(4), .W(8)) bus ();
  cory_unpackn_if #(.C(2), .W(8)) bus0 ();

  cory_unpackn #(.C(4), .W(8), .Q(1)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .a_if    (bus)
  );

  cory_unpackn #(.C(2), .W(8), .Q(0)) u_dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .a_if    (bus0)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] d;
    logic [31:0] exp_zd;
  } vec1_t;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        exp_ar;
    logic [1:0]  exp_zv;
  } vec0_t;

  vec1_t tbl1[5];
  vec0_t tbl0[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_a_v = 1'b0;
    bus.i_z_r = 4'hF;
`ifdef CORY_UNPACKN_MASK_EN
    bus.i_a_m = 4'hF;
`endif
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl1[0] = '{32'h44332211, 32'h44332211};
    tbl1[1] = '{32'h00000000, 32'h00000000};
    tbl1[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF};
    tbl1[3] = '{32'hA5C3_0F81, 32'hA5C3_0F81};
    tbl1[4] = '{32'h0102_0408, 32'h0102_0408};

    tbl0[0] = '{1'b0, 16'h1234, 1'b0, 2'b00};
    tbl0[1] = '{1'b1, 16'h1234, 1'b1, 2'b11};
    tbl0[2] = '{1'b1, 16'hBEEF, 1'b1, 2'b11};
    tbl0[3] = '{1'b0, 16'hBEEF, 1'b0, 2'b00};
    tbl0[4] = '{1'b1, 16'h00FF, 1'b1, 2'b11};
    tbl0[5] = '{1'b1, 16'h8001, 1'b1, 2'b11};

    reset_n    = 1'b0;
    bus.i_a_v  = 1'b0;
    bus.i_a_d  = '0;
    bus.i_z_r  = 4'hF;
    bus0.i_a_v = 1'b0;
    bus0.i_a_d = '0;
    bus0.i_z_r = 2'b11;
`ifdef CORY_UNPACKN_MASK_EN
    bus.i_a_m  = 4'hF;
    bus0.i_a_m = 2'b11;
`endif

    // Reset state
    repeat (2) tick();
    chk("rst_sent", 32'(bus.o_sent), 32'h0);
    chk("rst_zv", 32'(bus.o_z_v), 32'h0);
    chk("rst_ar", 32'(bus.o_a_r), 32'h0);
    reset_n = 1'b1;
    tick();
    @(negedge clk);
    chk("post_rst_zv", 32'(bus.o_z_v), 32'h0);

    // Case 6: Q=0, C=2 pass-through
    for (int i = 0; i < 6; i++) begin
      tick();
      bus0.i_a_v = tbl0[i].v;
      bus0.i_a_d = tbl0[i].d;
      #1;
      chk("c6_ar", 32'(bus0.o_a_r), 32'(tbl0[i].exp_ar));
      chk("c6_zv", 32'(bus0.o_z_v), 32'(tbl0[i].exp_zv));
      if (tbl0[i].v) chk("c6_zd", 32'(bus0.o_z_d), 32'(tbl0[i].d));
    end
    bus0.i_a_v = 1'b0;

    // Case 1: full-ready words, accept same cycle, output one cycle later
    for (int i = 0; i < 5; i++) begin
      tick();
      bus.i_z_r = 4'hF;
      bus.i_a_v = 1'b1;
      bus.i_a_d = tbl1[i].d;
      @(negedge clk);
      chk("c1_ar", 32'(bus.o_a_r), 32'h1);
      tick();
      bus.i_a_v = 1'b0;
      chk("c1_zv", 32'(bus.o_z_v), 32'hF);
      chk("c1_zd", bus.o_z_d, tbl1[i].exp_zd);
    end
    idle();

    // Case 2: lanes 1 and 3 stalled
    bus.i_z_r = 4'b0101;
    bus.i_a_v = 1'b1;
    bus.i_a_d = 32'h44332211;
    @(negedge clk);
    chk("c2_w1_ar", 32'(bus.o_a_r), 32'h1);
    tick();
    bus.i_a_d = 32'h88776655;
    @(negedge clk);
    chk("c2_cy1_zv", 32'(bus.o_z_v), 32'hF);
    chk("c2_cy1_ar", 32'(bus.o_a_r), 32'h0);
    chk("c2_cy1_sent", 32'(bus.o_sent), 32'h0);
    tick();
    @(negedge clk);
    chk("c2_cy2_zv", 32'(bus.o_z_v), 32'hA);
    chk("c2_cy2_ar", 32'(bus.o_a_r), 32'h0);
    tick();
    @(negedge clk);
    chk("c2_cy3_sent", 32'(bus.o_sent), 32'h5);
    chk("c2_cy3_zd", bus.o_z_d, 32'h44772255);
    chk("c2_cy3_ar", 32'(bus.o_a_r), 32'h0);
    tick();
    bus.i_z_r = 4'hF;
    @(negedge clk);
    chk("c2_cy4_ar", 32'(bus.o_a_r), 32'h0);
    chk("c2_cy4_zv", 32'(bus.o_z_v), 32'hA);
    tick();
    @(negedge clk);
    chk("c2_cy5_ar", 32'(bus.o_a_r), 32'h1);
    chk("c2_cy5_sent", 32'(bus.o_sent), 32'h5);
    tick();
    bus.i_a_v = 1'b0;
    chk("c2_cy6_zv", 32'(bus.o_z_v), 32'hA);
    chk("c2_cy6_l1", 32'(bus.o_z_d[15:8]), 32'h66);
    chk("c2_cy6_l3", 32'(bus.o_z_d[31:24]), 32'h88);
    chk("c2_cy6_sent", 32'(bus.o_sent), 32'h0);
    idle();

`ifdef CORY_UNPACKN_MASK_EN
    // Case 3: emit mask
    bus.i_a_m = 4'b1010;
    bus.i_a_v = 1'b1;
    bus.i_a_d = 32'hDDCCBBAA;
    @(negedge clk);
    chk("c3_m_ar", 32'(bus.o_a_r), 32'h1);
    tick();
    bus.i_a_v = 1'b0;
    chk("c3_m_zv", 32'(bus.o_z_v), 32'hA);
    chk("c3_m_l3", 32'(bus.o_z_d[31:24]), 32'hDD);
    tick();
    bus.i_a_m = 4'h0;
    bus.i_a_v = 1'b1;
    @(negedge clk);
    chk("c3_z_ar", 32'(bus.o_a_r), 32'h1);
    chk("c3_z_zv0", 32'(bus.o_z_v), 32'h0);
    tick();
    bus.i_a_v = 1'b0;
    bus.i_a_m = 4'hF;
    chk("c3_z_zv1", 32'(bus.o_z_v), 32'h0);
    idle();
`endif

    // Case 4: 8 back-to-back words with random per-lane ready
    begin
      int exp_n[4];
      int words;
      int cyc;
      bit all_done;
      for (int k = 0; k < 4; k++) exp_n[k] = 0;
      words    = 0;
      cyc      = 0;
      all_done = 1'b0;
      while (!all_done && cyc < 400) begin
        tick();
        cyc++;
        bus.i_z_r = 4'($urandom_range(0, 15));
        bus.i_a_v = (words < 8);
        bus.i_a_d = {4{8'(words)}};
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
          if (bus.o_z_v[k] && bus.i_z_r[k]) begin
            chk("c4_lane", 32'(bus.o_z_d[k*8 +: 8]), 32'(exp_n[k]));
            exp_n[k]++;
          end
        end
        if (bus.o_a_r && bus.i_a_v) words++;
        all_done = (exp_n[0] >= 8) && (exp_n[1] >= 8) && (exp_n[2] >= 8) && (exp_n[3] >= 8);
      end
      for (int k = 0; k < 4; k++) chk("c4_count", 32'(exp_n[k]), 32'd8);
      chk("c4_words", 32'(words), 32'd8);
      bus.i_a_v = 1'b0;
      bus.i_z_r = 4'hF;
      tick();
      chk("c4_drained", 32'(bus.o_z_v), 32'h0);
    end
    idle();

    // Case 5: reset mid-word with lanes 0,1 already sent
    bus.i_z_r = 4'b0011;
    bus.i_a_v = 1'b1;
    bus.i_a_d = 32'h13121110;
    @(negedge clk);
    chk("c5_w1_ar", 32'(bus.o_a_r), 32'h1);
    tick();
    bus.i_a_d = 32'h23222120;
    tick();
    tick();
    chk("c5_sent", 32'(bus.o_sent), 32'h3);
    reset_n = 1'b0;
    #1;
    chk("c5_rst_sent", 32'(bus.o_sent), 32'h0);
    chk("c5_rst_zv", 32'(bus.o_z_v), 32'h0);
    bus.i_a_v = 1'b0;
    tick();
    tick();
    reset_n   = 1'b1;
    bus.i_z_r = 4'hF;
    bus.i_a_v = 1'b1;
    bus.i_a_d = 32'h33323130;
    @(negedge clk);
    chk("c5_w3_ar", 32'(bus.o_a_r), 32'h1);
    tick();
    bus.i_a_v = 1'b0;
    chk("c5_w3_zv", 32'(bus.o_z_v), 32'hF);
    chk("c5_w3_zd", bus.o_z_d, 32'h33323130);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
